qspi_word_cache: RTL

Direct-mapped, write-through, no-write-allocate word cache between the CPU data/instruction bus and the QSPI PSRAM/flash controller. It absorbs repeated reads of the same 32-bit word so that they skip the multi-microsecond serial transfer. Toward the controller it issues single-word requests using the same valid/ready pulse protocol. Misses and all writes pass through unchanged.

---
 rtl/qspi_word_cache.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/qspi_word_cache.sv
// qspi_word_cache: direct-mapped, write-through, no-write-allocate word
// cache in front of the QSPI PSRAM/flash controller.
// Ports: clk, resetn (sync, active-low); cpu_valid/addr/wdata/wstrb in,
// cpu_rdata/cpu_ready out; inv invalidate-all pulse; mem_valid/addr/
// wdata/wstrb out, mem_rdata/mem_ready in; flushing marks the vbit sweep.
module qspi_word_cache #(
    parameter int CACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [22:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        inv,
    output logic        mem_valid,
    output logic [22:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        flushing
);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = 23 - IDX_W;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_MEM_RELEASE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_inv_pend;
    logic [22:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_rd_data;
    logic [TAG_W-1:0]   r_rd_tag;
    logic [CACHE_LINES-1:0] r_vbit;
    logic [31:0]        r_data [CACHE_LINES];
    logic [TAG_W-1:0]   r_tag  [CACHE_LINES];
    logic               r_cpu_ready;
    logic [31:0]        r_cpu_rdata;
    logic               r_mem_valid;
    logic [22:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_wstrb;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_is_wr;
    logic               w_hit;
    logic               w_accept;
    logic               w_rd_hit;
    logic               w_issue;
    logic               w_done;
    logic               w_fill;
    logic               w_merge;
    logic               w_last;
    logic [31:0]        w_merged;

    assign w_idx    = r_addr[IDX_W-1:0];
    assign w_tag    = r_addr[22:IDX_W];
    assign w_is_wr  = |r_wstrb;
    assign w_hit    = r_vbit[w_idx] && (r_rd_tag == w_tag);
    // Ready cycle is excluded so a still-high cpu_valid is not re-taken.
    assign w_accept = (r_state == S_IDLE) && !r_inv_pend
                   && cpu_valid && !r_cpu_ready;
    assign w_rd_hit = (r_state == S_LOOKUP) && !w_is_wr && w_hit;
    assign w_issue  = (r_state == S_LOOKUP) && !w_rd_hit;
    assign w_done   = (r_state == S_MEM_REQ) && mem_ready;
    assign w_fill   = w_done && !w_is_wr;
    assign w_merge  = (r_state == S_LOOKUP) && w_is_wr && w_hit;
    assign w_last   = (r_cnt == IDX_W'(CACHE_LINES - 1));

    always_comb begin
        w_merged = r_rd_data;
        for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FLUSH: begin
                if (!inv && w_last) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (r_inv_pend)    w_state_nxt = S_FLUSH;
                else if (w_accept) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                w_state_nxt = w_rd_hit ? S_IDLE : S_MEM_REQ;
            end
            S_MEM_REQ: begin
                if (mem_ready) w_state_nxt = S_MEM_RELEASE;
            end
            S_MEM_RELEASE: begin
                if (!mem_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_FLUSH;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_inv_pend  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            // inv inside the sweep restarts it from line 0.
            if (r_state == S_FLUSH) r_cnt <= inv ? '0 : r_cnt + 1'b1;
            else                    r_cnt <= '0;
            if (r_state == S_IDLE && r_inv_pend) begin
                r_inv_pend <= 1'b0;
            end else if (inv && r_state != S_FLUSH) begin
                r_inv_pend <= 1'b1;
            end
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_wstrb <= cpu_wstrb;
            end
            r_cpu_ready <= w_rd_hit || w_done;
            if (w_rd_hit)    r_cpu_rdata <= r_rd_data;
            else if (w_fill) r_cpu_rdata <= mem_rdata;
            if (w_issue) begin
                r_mem_valid <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= r_wdata;
                r_mem_wstrb <= r_wstrb;
            end else if (w_done) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    // Data/tag arrays: registered read port, no reset, BRAM friendly.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd_data <= r_data[cpu_addr[IDX_W-1:0]];
            r_rd_tag  <= r_tag[cpu_addr[IDX_W-1:0]];
        end
        if (w_merge)     r_data[w_idx] <= w_merged;
        else if (w_fill) r_data[w_idx] <= mem_rdata;
        if (w_fill)      r_tag[w_idx]  <= w_tag;
    end

    // Valid bits need no reset: the sweep after reset clears them.
    always_ff @(posedge clk) begin
        if (r_state == S_FLUSH) r_vbit[r_cnt] <= 1'b0;
        else if (w_fill)        r_vbit[w_idx] <= 1'b1;
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign flushing  = (r_state == S_FLUSH);
endmodule
